// File: rtl/sqrt_pkg.sv
// Shared types and width helpers for the sequential integer square-root unit.
// Widths are derived from the operand width so every file sizes its registers the same way.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Root width, running-square width and odd-delta width for a given operand width.
  function automatic int rw_of(input int width);
    return width / 2;
  endfunction

  function automatic int sqw_of(input int width);
    return width + 1;
  endfunction

  function automatic int dw_of(input int width);
    return width / 2 + 2;
  endfunction

  localparam int SQUARE_INIT = 1;
  localparam int DELTA_INIT  = 3;

endpackage

// File: rtl/sqrt_datapath.sv
// Odd-number accumulation datapath: latched operand, running square, odd delta and result.
// The controller sequences it through load, step and capture enables.
module sqrt_datapath
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               load,
  input  logic               step,
  input  logic               capture,
  input  logic [WIDTH-1:0]   sw,
  output logic               lte,
  output logic [WIDTH/2-1:0] root
);

  localparam int RW  = rw_of(WIDTH);
  localparam int SQW = sqw_of(WIDTH);
  localparam int DW  = dw_of(WIDTH);

  // Declaration initialisers give the same power-on state as clr.
  logic [WIDTH-1:0] a_reg      = '0;
  logic [SQW-1:0]   square_reg = SQW'(SQUARE_INIT);
  logic [DW-1:0]    delta_reg  = DW'(DELTA_INIT);
  logic [RW-1:0]    root_reg   = '0;
  logic [RW-1:0]    root_next;

  // delta = 2k+3 once the square has passed the operand, so the root is delta/2 - 1.
  assign root_next = RW'(delta_reg >> 1) - RW'(1);
  assign lte       = (square_reg <= {1'b0, a_reg});
  assign root      = root_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      a_reg      <= '0;
      square_reg <= SQW'(SQUARE_INIT);
      delta_reg  <= DW'(DELTA_INIT);
      root_reg   <= '0;
    end else begin
      if (load) begin
        a_reg      <= sw;
        square_reg <= SQW'(SQUARE_INIT);
        delta_reg  <= DW'(DELTA_INIT);
      end else if (step) begin
        square_reg <= square_reg + SQW'(delta_reg);
        delta_reg  <= delta_reg + DW'(2);
      end
      if (capture) begin
        root_reg <= root_next;
      end
    end
  end

endmodule

// File: rtl/sqrt.sv
// Sequential integer square root: root = floor(sqrt(sw)) via odd-number accumulation.
// A three-state controller drives the datapath under a go/done handshake.
module sqrt
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               go,
  input  logic [WIDTH-1:0]   sw,
  output logic               done,
  output logic [WIDTH/2-1:0] root
);

  state_t state_reg = IDLE;
  state_t state_next;
  logic   load;
  logic   step;
  logic   capture;
  logic   lte;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    capture    = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (go) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (lte) begin
          step = 1'b1;
        end else begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        // Result stays presented until the requester drops go.
        if (!go) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  sqrt_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk    (clk),
    .clr    (clr),
    .load   (load),
    .step   (step),
    .capture(capture),
    .sw     (sw),
    .lte    (lte),
    .root   (root)
  );

endmodule

// File: tb/tb_sqrt.sv
// Directed bench for the sequential square-root unit: latency, hold, reset abort,
// ignored inputs during calculation and a full 8-bit sweep against floor(sqrt).
module tb_sqrt;

  logic       clk = 1'b0;
  logic       clr;
  logic       go;
  logic [7:0] sw;
  logic       done;
  logic [3:0] root;

  int errors = 0;
  int checks = 0;

  sqrt #(
    .WIDTH(8)
  ) dut (
    .clk (clk),
    .clr (clr),
    .go  (go),
    .sw  (sw),
    .done(done),
    .root(root)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One go-pulse transaction; go drops right after the load edge, so DONE lasts one cycle.
  task automatic run(input logic [7:0] v, input int exp_root, input string tag);
    int n;
    bit seen;
    @(negedge clk);
    sw = v;
    go = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (done) seen = 1'b1;
      else if (n == 1) go = 1'b0;
    end
    go = 1'b0;
    $display("%s: sw=%0d root=%0d edges=%0d", tag, v, root, n);
    check({tag, "_edges"}, 32'(n), 32'(exp_root + 2));
    check({tag, "_root"}, 32'(root), 32'(exp_root));
    @(posedge clk);
    #1;
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_idle_root"}, 32'(root), 32'(exp_root));
  endtask

  initial begin
    int n;
    bit seen;
    int r;

    // Power-up with clr never asserted, go held high from time 0.
    clr = 1'b0;
    go  = 1'b1;
    sw  = 8'd64;
    #1;
    check("por_done", 32'(done), 32'd0);
    check("por_root", 32'(root), 32'd0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      @(posedge clk);
      n++;
      #1;
      if (done) seen = 1'b1;
    end
    $display("por: sw=64 root=%0d edges=%0d t=%0t", root, n, $time);
    check("por_edges", 32'(n), 32'd10);
    check("por_time", 32'($time), 32'd191);
    check("por_root8", 32'(root), 32'd8);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("hold_done", 32'(done), 32'd1);
      check("hold_root", 32'(root), 32'd8);
    end

    // Dropping go in DONE returns to IDLE, root keeps the last result.
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    #1;
    $display("drop: done=%0d root=%0d", done, root);
    check("drop_done", 32'(done), 32'd0);
    check("drop_root", 32'(root), 32'd8);

    run(8'd0,   0,  "sw0");
    run(8'd255, 15, "sw255");
    run(8'd63,  7,  "sw63");
    run(8'd1,   1,  "sw1");
    run(8'd144, 12, "sw144");

    // clr for one edge in the middle of a calculation.
    @(negedge clk);
    sw = 8'd200;
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    $display("clr: done=%0d root=%0d", done, root);
    check("clr_done", 32'(done), 32'd0);
    check("clr_root", 32'(root), 32'd0);
    clr = 1'b0;
    @(posedge clk);
    #1;
    check("clr_idle_done", 32'(done), 32'd0);
    check("clr_idle_root", 32'(root), 32'd0);
    run(8'd200, 14, "after_clr");

    // sw and go are ignored once the operand has been loaded.
    @(negedge clk);
    sw = 8'd100;
    go = 1'b1;
    @(posedge clk);
    n = 1;
    #1;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      sw = 8'd9;
      go = ~go;
      @(posedge clk);
      n++;
      #1;
      if (done) seen = 1'b1;
    end
    go = 1'b0;
    $display("ignore: sw=100 root=%0d edges=%0d", root, n);
    check("ign_edges", 32'(n), 32'd12);
    check("ign_root", 32'(root), 32'd10);
    @(posedge clk);
    #1;
    check("ign_idle_done", 32'(done), 32'd0);

    for (int v = 0; v < 256; v++) begin
      r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      run(v[7:0], r, "sweep");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
